// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for mem_port_arbiter and its tag queue.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_SRC_I = 1'b0,
    ARB_SRC_D = 1'b1
  } arb_src_e;

  localparam int unsigned MEMARB_MAX_OUTSTANDING = 4;
  localparam int unsigned MEMARB_STARVE_LIMIT    = 8;

  function automatic arb_src_e arb_other(input arb_src_e src);
    return (src == ARB_SRC_I) ? ARB_SRC_D : ARB_SRC_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// In-order 1-bit source-tag queue; head is read straight from the registered slots.
module arb_tag_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = MEMARB_MAX_OUTSTANDING,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  arb_src_e      push_tag,
  input  logic          pop,
  output arb_src_e      head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  arb_src_e      slots [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_tag;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I fetch and D load/store; routes responses by tag.
// Define MEMARB_RR_EN for round-robin arbitration instead of fixed D priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MEMARB_MAX_OUTSTANDING,
  parameter int unsigned STARVE_LIMIT    = MEMARB_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] im_req_addr,
  input  logic        im_req_valid,
  output logic        im_req_ready,
  output logic [63:0] im_resp_rdata,
  output logic        im_resp_valid,
  input  logic [63:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic [7:0]  dm_req_wmask,
  input  logic        dm_req_wen,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  output logic [63:0] dm_resp_rdata,
  output logic        dm_resp_valid,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  output logic        mem_req_wen,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  input  logic [63:0] mem_resp_rdata,
  input  logic        mem_resp_valid,
  output logic        arb_err
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [CW-1:0] outstanding;
  logic          q_full;
  logic          q_empty;
  arb_src_e      q_head;
  arb_src_e      push_tag;
  logic          push;
  logic          pop;
  logic          can_issue;
  logic          d_wins_tie;
  logic          grant_d;
  logic          grant_i;

`ifdef MEMARB_RR_EN
  arb_src_e rr_ptr;

  assign d_wins_tie = (rr_ptr == ARB_SRC_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= ARB_SRC_D;
    end else if (push) begin
      rr_ptr <= arb_other(push_tag);
    end
  end
`else
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          i_forced;

  assign i_forced   = (starve_cnt == SW'(STARVE_LIMIT));
  assign d_wins_tie = !i_forced;

  // Saturates at the limit so I keeps winning ties until it is finally accepted.
  always_ff @(posedge clk) begin
    if (rst || !im_req_valid || im_req_ready) begin
      starve_cnt <= '0;
    end else if (!i_forced) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`endif

  assign can_issue = !rst && (outstanding < CW'(MAX_OUTSTANDING));
  assign grant_d   = dm_req_valid && (!im_req_valid || d_wins_tie);
  assign grant_i   = im_req_valid && !grant_d;

  assign mem_req_valid = can_issue && (im_req_valid || dm_req_valid);
  assign im_req_ready  = grant_i && can_issue && mem_req_ready;
  assign dm_req_ready  = grant_d && can_issue && mem_req_ready;

  always_comb begin
    mem_req_addr  = im_req_addr;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    mem_req_wen   = 1'b0;
    if (grant_d) begin
      mem_req_addr  = dm_req_addr;
      mem_req_wdata = dm_req_wdata;
      mem_req_wmask = dm_req_wmask;
      mem_req_wen   = dm_req_wen;
    end
  end

  assign push     = im_req_ready || dm_req_ready;
  assign push_tag = dm_req_ready ? ARB_SRC_D : ARB_SRC_I;
  assign pop      = !rst && mem_resp_valid && !q_empty;

  arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (q_head),
    .count    (outstanding),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign im_resp_rdata = mem_resp_rdata;
  assign dm_resp_rdata = mem_resp_rdata;
  assign im_resp_valid = pop && (q_head == ARB_SRC_I);
  assign dm_resp_valid = pop && (q_head == ARB_SRC_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_err <= 1'b0;
    end else if (mem_resp_valid && q_empty) begin
      arb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && q_full));
    end
  end

endmodule
